// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth radix-4 partial-product reduction path.
// Widths here must match the upstream 24x24 partial-product generator.
package booth_pkg;

    localparam int PP_W   = 26;
    localparam int PP_N   = 13;
    localparam int PROD_W = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [PROD_W-1:0] sext_pp(input logic [PP_W-1:0] pp);
        return {{(PROD_W-PP_W){pp[PP_W-1]}}, pp};
    endfunction

endpackage

// File: rtl/booth_pp_align.sv
// Aligns one partial product to its radix-4 weight: sext(pp) << 2k.
// Purely combinational; bits shifted past the product width are dropped.
module booth_pp_align
    import booth_pkg::*;
(
    input  logic [PP_W-1:0]   pp,
    input  logic [3:0]        k,
    output logic [PROD_W-1:0] pp_aligned
);

    assign pp_aligned = sext_pp(pp) << {k, 1'b0};

endmodule

// File: rtl/booth_pp_accum.sv
// Multi-cycle reducer: captures 13 Booth partial products, adds one per clock
// into a 48-bit accumulator and presents the product under valid/ready.
module booth_pp_accum
    import booth_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [PP_W-1:0]   ipp1,
    input  logic [PP_W-1:0]   ipp2,
    input  logic [PP_W-1:0]   ipp3,
    input  logic [PP_W-1:0]   ipp4,
    input  logic [PP_W-1:0]   ipp5,
    input  logic [PP_W-1:0]   ipp6,
    input  logic [PP_W-1:0]   ipp7,
    input  logic [PP_W-1:0]   ipp8,
    input  logic [PP_W-1:0]   ipp9,
    input  logic [PP_W-1:0]   ipp10,
    input  logic [PP_W-1:0]   ipp11,
    input  logic [PP_W-1:0]   ipp12,
    input  logic [PP_W-1:0]   ipp13,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] oprod,
    output logic              oprod_signed
);

    localparam logic [3:0] K_LAST = 4'(PP_N - 1);

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          k_q;
    logic [PROD_W-1:0]   acc_q;
    logic                sig_q;
    logic                accept;
    logic [PP_W-1:0]     ipp_v [PP_N];
    logic [PP_W-1:0]     bank  [1:PP_N-1];
    logic [PP_W-1:0]     align_pp;
    logic [3:0]          align_k;
    logic [PROD_W-1:0]   aligned;

    assign ipp_v[0]  = ipp1;
    assign ipp_v[1]  = ipp2;
    assign ipp_v[2]  = ipp3;
    assign ipp_v[3]  = ipp4;
    assign ipp_v[4]  = ipp5;
    assign ipp_v[5]  = ipp6;
    assign ipp_v[6]  = ipp7;
    assign ipp_v[7]  = ipp8;
    assign ipp_v[8]  = ipp9;
    assign ipp_v[9]  = ipp10;
    assign ipp_v[10] = ipp11;
    assign ipp_v[11] = ipp12;
    assign ipp_v[12] = ipp13;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = ACCUM;
            end
            ACCUM: begin
                if (k_q == K_LAST) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = accept ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (1'b1)
            (state_q == IDLE): in_ready = 1'b1;
            (state_q == DONE): begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // A load reuses the aligner at weight 0 so the accumulator has one input path.
    assign align_pp = accept ? ipp1 : bank[k_q];
    assign align_k  = accept ? 4'd0 : k_q;

    booth_pp_align u_align (
        .pp         (align_pp),
        .k          (align_k),
        .pp_aligned (aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            k_q   <= 4'd0;
            sig_q <= 1'b0;
        end else if (accept) begin
            acc_q <= aligned;
            k_q   <= 4'd1;
            sig_q <= in_signed;
        end else if (state_q == ACCUM) begin
            acc_q <= acc_q + aligned;
            if (k_q != K_LAST) k_q <= k_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 1; i < PP_N; i++) begin
                bank[i] <= ipp_v[i];
            end
        end
    end

    assign oprod        = acc_q;
    assign oprod_signed = sig_q;

endmodule

// File: tb/tb_booth_pp_accum.sv
// Directed plus randomized checks of booth_pp_accum against an arithmetic
// model: sum over k of signed(pp[k]) * 4^k, taken mod 2^48.
module tb_booth_pp_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [25:0] ipp [13];
    logic        out_valid;
    logic        out_ready;
    logic [47:0] oprod;
    logic        oprod_signed;

    int total  = 0;
    int passed = 0;

    logic [47:0] exp_prod;
    logic        exp_sig;
    logic [47:0] held;
    int          lat;

    always #5 clk = ~clk;

    booth_pp_accum dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_signed    (in_signed),
        .ipp1         (ipp[0]),
        .ipp2         (ipp[1]),
        .ipp3         (ipp[2]),
        .ipp4         (ipp[3]),
        .ipp5         (ipp[4]),
        .ipp6         (ipp[5]),
        .ipp7         (ipp[6]),
        .ipp8         (ipp[7]),
        .ipp9         (ipp[8]),
        .ipp10        (ipp[9]),
        .ipp11        (ipp[10]),
        .ipp12        (ipp[11]),
        .ipp13        (ipp[12]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .oprod        (oprod),
        .oprod_signed (oprod_signed)
    );

    function automatic logic [47:0] model();
        longint s = 0;
        for (int k = 0; k < 13; k++) begin
            s += longint'($signed(ipp[k])) * (longint'(1) << (2 * k));
        end
        return s[47:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pp();
        for (int i = 0; i < 13; i++) ipp[i] = 26'h0;
    endtask

    task automatic rand_pp();
        for (int i = 0; i < 13; i++) ipp[i] = 26'($urandom);
    endtask

    // Presents the current set, captures the model's answer, accepts on the next edge.
    task automatic accept_set(input logic sig);
        exp_prod  = model();
        exp_sig   = sig;
        in_signed = sig;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    // Counts edges until out_valid; optionally scrambles inputs meanwhile.
    task automatic wait_out(input bit noise, output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            if (noise) begin
                rand_pp();
                in_valid  = 1'($urandom);
                in_signed = 1'($urandom);
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic sig,
                             input bit noise);
        accept_set(sig);
        chk({tag, "_busy"}, 64'(in_ready), 64'd0);
        wait_out(noise, lat);
        chk({tag, "_lat"}, 64'(lat), 64'd12);
        chk({tag, "_prod"}, 64'(oprod), 64'(exp_prod));
        chk({tag, "_sig"}, 64'(oprod_signed), 64'(exp_sig));
        consume();
        chk({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        clear_pp();
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_oprod", 64'(oprod), 64'd0);
        chk("rst_sig", 64'(oprod_signed), 64'd0);
        rst = 1'b0;
        tick();

        ipp[0] = 26'h3;
        ipp[1] = 26'h3;
        run_check("u3x5", 1'b0, 1'b0);
        chk("u3x5_const", 64'(exp_prod), 64'd15);

        clear_pp();
        ipp[0]  = 26'h3000001;
        ipp[12] = 26'h0FFFFFF;
        accept_set(1'b0);
        wait_out(1'b0, lat);
        chk("umax_prod", 64'(oprod), 64'hFFFFFE000001);
        consume();

        clear_pp();
        ipp[0] = 26'h1;
        accept_set(1'b1);
        wait_out(1'b0, lat);
        chk("sm1_prod", 64'(oprod), 64'h1);
        chk("sm1_sig", 64'(oprod_signed), 64'd1);
        consume();

        for (int i = 0; i < 13; i++) ipp[i] = 26'h3FFFFFF;
        accept_set(1'b1);
        wait_out(1'b0, lat);
        chk("allneg_prod", 64'(oprod), 64'hFFFFFEAAAAAB);
        consume();

        for (int t = 0; t < 8; t++) begin
            rand_pp();
            run_check($sformatf("rnd%0d", t), 1'($urandom), 1'b1);
        end

        rand_pp();
        accept_set(1'b1);
        wait_out(1'b0, lat);
        held = oprod;
        chk("bp_prod", 64'(held), 64'(exp_prod));
        rand_pp();
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("bp_hold", 64'({in_ready, out_valid, oprod}),
                64'({1'b0, 1'b1, held}));
        end
        exp_prod  = model();
        exp_sig   = 1'b0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_reaccept", 64'({in_ready, out_valid}), 64'd0);
        wait_out(1'b0, lat);
        chk("bp_lat", 64'(lat), 64'd12);
        chk("bp_prod2", 64'(oprod), 64'(exp_prod));
        consume();

        rand_pp();
        accept_set(1'b1);
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        #1;
        chk("mrst_now", 64'({in_ready, out_valid, oprod_signed, oprod}),
            64'({1'b1, 1'b0, 1'b0, 48'h0}));
        #2;
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            chk("mrst_novalid", 64'(out_valid), 64'd0);
        end
        clear_pp();
        ipp[0] = 26'h3;
        ipp[1] = 26'h3;
        run_check("mrst_3x5", 1'b0, 1'b0);
        chk("mrst_const", 64'(exp_prod), 64'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout observed=running expected=finished");
    end

endmodule

// File: doc/booth_pp_accum.md
# booth_pp_accum

Sequential reduction stage that sits directly downstream of the 24x24 Booth radix-4 partial-product generator. It captures the 13 signed 26-bit partial products of one multiplication under a valid/ready handshake. It sums them, each shifted by 2k, one per clock into a 48-bit accumulator, then holds the finished product under a second valid/ready handshake. Together the two blocks form a compact multi-cycle 24x24 signed/unsigned multiplier.

## Interface
- PP_W, 26, width of one partial product (two's complement)
- PP_N, 13, number of partial products
- PROD_W, 48, product width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  partial-product set valid
- in_ready  out  1  block can accept a set
- in_signed  in  1  tag: 1 if either operand was signed; passed through
- ipp1 … ipp13  in  26 each  partial products, ipp(k+1) has weight 4^k
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- oprod  out  48  product, two's complement mod 2^48
- oprod_signed  out  1  captured in_signed

## Operation
- States: IDLE, ACCUM, DONE.
- **IDLE:** in_ready=1.
  - On accept (in_valid&in_ready), register ipp2..ipp13 into a 12-entry bank.
  - Load acc = sext48(ipp1).
  - Set k=1, capture in_signed, go to ACCUM.
- **ACCUM:** in_ready=0.
  - Each edge: acc += sext48(pp[k]) << 2k, truncated to 48 bits; k++.
  - After the add of pp[12], go to DONE.
- **DONE:** out_valid=1; oprod=acc; oprod_signed=captured tag.
  - On out_valid&out_ready: go to IDLE.
  - If in_valid is also high in that cycle, accept the new set and go straight to ACCUM.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Arithmetic:
  - Sign-extend every partial product from bit 25 before shifting.
  - Discard the carry out of bit 47.
  - For unsigned×unsigned the result is exact. For signed operands it is the exact 48-bit two's-complement product.
- k is a 4-bit counter spanning 1..12; values 13–15 are unreachable.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, oprod=0, oprod_signed=0, k=0, acc=0.
- Latency: accept at edge E0 gives out_valid high after edge E12 (12 clocks).
- Throughput: one product every 13 clocks with out_ready held high and back-to-back in_valid.
- oprod and oprod_signed are stable while out_valid=1 and out_ready=0; they change only on the next load.
- in_valid while in ACCUM is ignored: no capture, and the block does not need the input held.
- rst mid-ACCUM or mid-DONE:
  - Returns immediately to reset values.
  - The in-flight product is lost and out_valid is never asserted for it.
- Bank registers are not reset; they are written only on accept.

## Structure
- Package booth_pkg holds:
  - localparams PP_W=26, PP_N=13, PROD_W=48
  - state enum {IDLE, ACCUM, DONE}
  - function sext_pp(26→48)
- One natural sub-module, booth_pp_align: combinational; inputs pp[25:0] and k[3:0]; output 48-bit sext(pp)<<2k. Instantiated once on the accumulator input mux.
- Accumulator, counter, FSM and bank live in the top module.

## Test plan
- **Unsigned 3×5:** ipp1=26'h3, ipp2=26'h3, rest 0, in_signed=0 → out_valid 12 clocks after accept; oprod=48'd15; oprod_signed=0.
- **Unsigned max:** ipp1=26'h3000001, ipp13=26'h0FFFFFF, rest 0 → oprod=48'hFFFFFE000001.
- **Signed (-1)×(-1) and all-negative sum:**
  - ipp1=26'h0000001, rest 0, in_signed=1 → oprod=48'h1, oprod_signed=1.
  - All 13 ipp=26'h3FFFFFF → oprod=48'hFFFFFEAAAAAB.
- **Backpressure:**
  - Hold out_ready=0 for 20 clocks in DONE → oprod stable, in_ready=0.
  - Raise out_ready with in_valid=1 → the new set is accepted that same edge; next out_valid follows 12 clocks later.
- **Mid-operation reset:** assert rst 5 clocks after accept → in_ready=1 and out_valid=0 immediately. A subsequent 3×5 set still yields 48'd15.
- **Ignored input:** toggle in_valid and change ipp values during ACCUM → result still matches the originally accepted set.
